// File: rtl/serial_mag_comp.sv
`default_nettype none
// ============================================================================
// Module   : serial_mag_comp
// Purpose  : Bit-serial unsigned magnitude comparator. Operands are captured
//            on an accepted start, then one bit pair per clock is compared,
//            MSB first. The first differing bit decides the verdict; with
//            EARLY_EXIT=1 the operation ends on that bit, otherwise the scan
//            always runs down to bit 0.
// Ports    : clk      - rising-edge clock
//            rst      - synchronous active-high reset
//            start    - begin request, only honoured in IDLE
//            A, B     - operands, captured on the accepted start edge
//            busy     - high in SHIFT and DONE
//            done     - one-cycle pulse, flags valid from this cycle on
//            Gt/Eq/Le - A>B / A==B / A<B, held until next start or reset
//            bit_idx  - index of the bit under comparison (debug)
// Revision : 1.0 - initial release
// ============================================================================
module serial_mag_comp #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  output logic                   busy,
  output logic                   done,
  output logic                   Gt,
  output logic                   Eq,
  output logic                   Le,
  output logic [$clog2(WIDTH):0] bit_idx
);

  localparam int IW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_a, w_a;
  logic [WIDTH-1:0] r_b, w_b;
  logic [IW-1:0]    r_idx, w_idx;
  logic             r_dec, w_dec;      // a decision has been latched
  logic             r_gt, w_gt;
  logic             r_eq, w_eq;
  logic             r_le, w_le;
  logic             r_busy, w_busy;
  logic             r_done, w_done;

  logic             w_a_bit, w_b_bit;
  logic             w_new_dec;         // first differing bit seen this cycle

  assign w_a_bit   = r_a[WIDTH-1];
  assign w_b_bit   = r_b[WIDTH-1];
  assign w_new_dec = (w_a_bit != w_b_bit) && !r_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_dec   <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_le    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_a     <= w_a;
      r_b     <= w_b;
      r_idx   <= w_idx;
      r_dec   <= w_dec;
      r_gt    <= w_gt;
      r_eq    <= w_eq;
      r_le    <= w_le;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_a     = r_a;
    w_b     = r_b;
    w_idx   = r_idx;
    w_dec   = r_dec;
    w_gt    = r_gt;
    w_eq    = r_eq;
    w_le    = r_le;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a     = A;
          w_b     = B;
          w_idx   = IW'(WIDTH - 1);
          w_dec   = 1'b0;
          w_gt    = 1'b0;
          w_eq    = 1'b0;
          w_le    = 1'b0;
          w_state = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (w_new_dec) begin
          w_dec = 1'b1;
          w_gt  = w_a_bit & ~w_b_bit;
          w_le  = ~w_a_bit & w_b_bit;
        end
        if (EARLY_EXIT && w_new_dec) begin
          w_state = S_DONE;
        end else if (r_idx == '0) begin
          // Equal only if no bit, including this last one, ever differed.
          w_eq    = !r_dec && !w_new_dec;
          w_state = S_DONE;
        end else begin
          w_a   = r_a << 1;
          w_b   = r_b << 1;
          w_idx = r_idx - IW'(1);
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the next-state decode.
    w_busy = (w_state != S_IDLE);
    w_done = (w_state == S_DONE);
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign Gt      = r_gt;
  assign Eq      = r_eq;
  assign Le      = r_le;
  assign bit_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_comp.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_mag_comp
// Purpose  : Self-checking bench for serial_mag_comp. Two instances share the
//            stimulus: one with early exit, one scanning all bits. Expected
//            flags and latency are queued when an operation is started and
//            compared when the selected instance raises done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_mag_comp;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;

  logic         busy1, done1, gt1, eq1, le1;
  logic [3:0]   idx1;
  logic         busy0, done0, gt0, eq0, le0;
  logic [3:0]   idx0;

  logic         sel;      // 1 = early-exit instance, 0 = full-scan instance
  logic         s_busy, s_done;
  logic [2:0]   s_flags;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] flags;    // {Gt, Eq, Le}
    int         lat;
  } exp_t;

  exp_t sb[$];

  serial_mag_comp #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy1), .done(done1), .Gt(gt1), .Eq(eq1), .Le(le1), .bit_idx(idx1)
  );

  serial_mag_comp #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_full (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy0), .done(done0), .Gt(gt0), .Eq(eq0), .Le(le0), .bit_idx(idx0)
  );

  assign s_busy  = sel ? busy1 : busy0;
  assign s_done  = sel ? done1 : done0;
  assign s_flags = sel ? {gt1, eq1, le1} : {gt0, eq0, le0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain relational compare plus edge count to the deciding bit.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ee);
    exp_t       e;
    logic [W-1:0] x;
    e.flags = {a > b, a == b, a < b};
    e.lat   = W + 1;
    x       = a ^ b;
    if (ee && x != '0) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (x[i]) begin
          e.lat = (W - 1 - i) + 2;
          break;
        end
      end
    end
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((busy0 || busy1) && n < 40) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy0 | busy1}, 32'd0);
  endtask

  // Called at posedge+1ns. Drives one start, then tracks the selected
  // instance until done, checking flags, latency and busy length.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ee, input logic restart, input int exp_busy);
    exp_t e;
    int   n;
    int   busy_cnt;
    bit   seen;
    sel   = ee;
    A     = a;
    B     = b;
    start = 1'b1;
    sb.push_back(model(a, b, ee));
    tick();
    start = 1'b0;
    n        = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    check({tag, "_clr"}, {29'd0, s_flags}, 32'd0);
    if (ee) check({tag, "_idx0"}, {28'd0, idx1}, 32'd7);
    while (n < 40) begin
      busy_cnt += int'(s_busy);
      if (s_done) begin
        seen = 1'b1;
        e    = sb.pop_front();
        check({tag, "_flags"}, {29'd0, s_flags}, {29'd0, e.flags});
        check({tag, "_lat"}, n, e.lat);
        if (exp_busy > 0) check({tag, "_busy"}, busy_cnt, exp_busy);
        break;
      end
      if (restart && n == 3) begin
        A     = ~a;
        B     = b;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    tick();
    check({tag, "_pulse"}, {30'd0, s_done, s_busy}, 32'd0);
    check({tag, "_hold"}, {29'd0, s_flags}, {29'd0, e.flags});
  endtask

  initial begin
    int cnt;
    logic [W-1:0] ra, rb;

    sel   = 1'b1;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_outs", {busy1, done1, gt1, eq1, le1, idx1}, 32'd0);
    check("rst_outs_full", {busy0, done0, gt0, eq0, le0, idx0}, 32'd0);

    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(done1) + int'(done0) + int'(busy1) + int'(busy0);
    end
    check("idle_quiet", cnt, 0);

    run_op("msb", 8'h80, 8'h7F, 1'b1, 1'b0, 2);
    wait_idle();
    run_op("eq", 8'hA5, 8'hA5, 1'b1, 1'b0, 9);
    wait_idle();
    run_op("late", 8'h10, 8'h11, 1'b1, 1'b1, 9);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      cnt += int'(done1);
    end
    check("no_second_op", cnt, 0);
    check("late_flags_kept", {29'd0, gt1, eq1, le1}, 32'd1);
    wait_idle();
    run_op("full", 8'h40, 8'h3F, 1'b0, 1'b0, 9);
    wait_idle();

    // Reset in the middle of an operation: start edge is edge 1, reset at edge 4.
    A     = 8'h01;
    B     = 8'h02;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outs", {busy1, done1, gt1, eq1, le1, idx1}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      cnt += int'(done1) + int'(done0);
    end
    check("midrst_no_done", cnt, 0);

    // Back-to-back random operations, each started in the cycle after done.
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if (i == 0) rb = ra;
      run_op($sformatf("rnd%0d", i), ra, rb, 1'b1, 1'b0, 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
